// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter (core load/store port vs. JPEG DMA).
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MAXWAIT = 8;

  // Counter width able to hold 0..maxwait; never narrower than one bit.
  function automatic int starve_cnt_width(input int maxwait);
    return (maxwait < 1) ? 1 : $clog2(maxwait + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating DMA wait counter; flags when the DMA has waited MAXWAIT consecutive cycles.
module arb_starve_counter
  import ram_arb_pkg::*;
#(
  parameter int MAXWAIT = DEF_MAXWAIT
) (
  input  logic clock,
  input  logic reset,
  input  logic waiting,
  output logic expired
);

  localparam int CW = starve_cnt_width(MAXWAIT);
  localparam logic [CW-1:0] LIMIT = CW'(MAXWAIT);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!waiting) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data-RAM arbiter: core has priority, DMA is served otherwise; read data is steered
// back one cycle later by a registered owner tag. Define ARB_STARVE_GUARD_EN to bound DMA waiting.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAXWAIT = DEF_MAXWAIT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  output logic             core_stall,
  output logic             core_rvalid,
  output logic [WIDTH-1:0] core_rdata,
  input  logic             dma_valid,
  output logic             dma_ready,
  input  logic             dma_we,
  input  logic [WIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_rvalid,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  owner_t grant;
  owner_t tag;
  logic   starve_expired;
  logic   dma_waiting;

  // Reset is folded in combinationally so every output reads 0 while it is held.
  always_comb begin
    grant = OWN_NONE;
    if (!reset) begin
      if (dma_valid && starve_expired) grant = OWN_DMA;
      else if (core_req)               grant = OWN_CORE;
      else if (dma_valid)              grant = OWN_DMA;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (grant)
      OWN_CORE: begin
        ram_en    = 1'b1;
        ram_we    = core_we;
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
      end
      OWN_DMA: begin
        ram_en    = 1'b1;
        ram_we    = dma_we;
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign core_stall  = core_req & ~reset & (grant != OWN_CORE);
  assign dma_ready   = dma_valid & (grant == OWN_DMA);
  assign dma_waiting = dma_valid & ~dma_ready;

  // Tag remembers who owns the read data arriving next cycle; writes return nothing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag <= OWN_NONE;
    end else if (ram_en && !ram_we) begin
      tag <= grant;
    end else begin
      tag <= OWN_NONE;
    end
  end

  assign core_rvalid = (tag == OWN_CORE);
  assign dma_rvalid  = (tag == OWN_DMA);
  assign core_rdata  = core_rvalid ? ram_rdata : '0;
  assign dma_rdata   = dma_rvalid  ? ram_rdata : '0;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .MAXWAIT (MAXWAIT)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .waiting (dma_waiting),
    .expired (starve_expired)
  );
`else
  logic unused_starve;
  assign starve_expired = 1'b0;
  assign unused_starve  = dma_waiting & (MAXWAIT > 0);
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, directed corner sequences, random traffic
// against a cycle-level reference model. Honours ARB_STARVE_GUARD_EN like the design.
module tb_ram_arbiter;

  localparam int WIDTH   = 32;
  localparam int MAXWAIT = 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dma_valid, dma_ready, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clock = ~clock;

  ram_arbiter #(.WIDTH(WIDTH), .MAXWAIT(MAXWAIT)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM driven by the arbiter.
  logic [31:0] ram_mem [256];
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr[7:0]];
    end
  end

  // Reference model: what memory should hold, who gets the next read return, DMA wait length.
  logic [31:0] exp_mem [256];
  int          ret_owner;   // 0 none, 1 core, 2 dma
  logic [31:0] ret_data;
  int          wait_cycles;
  int          last_g;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_owner();
    if (reset) return 0;
    if (GUARD && dma_valid && wait_cycles >= MAXWAIT) return 2;
    if (core_req) return 1;
    if (dma_valid) return 2;
    return 0;
  endfunction

  // One clock: check every output at the falling edge, then advance the model at the rising edge.
  task automatic step();
    int          g;
    bit          we;
    logic [31:0] a, w;
    bit          rc, rd;
    @(negedge clock);
    g  = model_owner();
    we = (g == 1) ? core_we : (g == 2) ? dma_we : 1'b0;
    a  = (g == 1) ? core_addr : (g == 2) ? dma_addr : 32'h0;
    w  = (g == 1) ? core_wdata : (g == 2) ? dma_wdata : 32'h0;
    rc = !reset && ret_owner == 1;
    rd = !reset && ret_owner == 2;
    check("core_stall", core_stall, core_req && g != 1 && !reset);
    check("dma_ready", dma_ready, g == 2);
    check("ram_en", ram_en, g != 0);
    check("ram_we", ram_we, we);
    check("ram_addr", ram_addr, a);
    check("ram_wdata", ram_wdata, w);
    check("core_rvalid", core_rvalid, rc);
    check("core_rdata", core_rdata, rc ? ret_data : 32'h0);
    check("dma_rvalid", dma_rvalid, rd);
    check("dma_rdata", dma_rdata, rd ? ret_data : 32'h0);
    last_g = g;
    @(posedge clock);
    if (reset) begin
      ret_owner   = 0;
      wait_cycles = 0;
    end else begin
      ret_owner = (g != 0 && !we) ? g : 0;
      if (g != 0 && !we) ret_data = exp_mem[a[7:0]];
      if (g != 0 && we) exp_mem[a[7:0]] = w;
      if (dma_valid && g != 2) wait_cycles = (wait_cycles < MAXWAIT) ? wait_cycles + 1 : MAXWAIT;
      else wait_cycles = 0;
    end
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dma_valid = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic core_load(input logic [31:0] a);
    core_req = 1; core_we = 0; core_addr = a; core_wdata = 0;
  endtask

  typedef struct {
    bit          cr, cw, dv, dw;
    logic [31:0] ca, da;
    bit          e_stall, e_ready, e_en, e_we;
  } vec_t;

  vec_t        vt [8];
  logic [31:0] rec [4];
  int          first_ready;
  int          pulses;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = (i == 8'h10) ? 32'hCAFE0001 : $urandom;
      ram_mem[i] <= v;
      exp_mem[i] = v;
    end
    ret_owner = 0; ret_data = 0; wait_cycles = 0; last_g = 0;
    idle();
    reset = 1;
    @(posedge clock); #1;

    // Reset state with requests present: everything must stay 0.
    core_load(32'h10);
    dma_valid = 1;
    step();
    idle();
    step();
    reset = 0;
    step();

    // 1: core load 0x10, DMA idle.
    core_load(32'h10);
    #1 check("t1_stall", core_stall, 1'b0);
    check("t1_en", ram_en, 1'b1);
    step();
    idle();
    #1 check("t1_rvalid", core_rvalid, 1'b1);
    check("t1_rdata", core_rdata, 32'hCAFE0001);
    check("t1_dma_rvalid", dma_rvalid, 1'b0);
    step();

    // 2: core store and DMA read of the same address collide.
    core_req = 1; core_we = 1; core_addr = 32'h40; core_wdata = 32'hDEADBEEF;
    dma_valid = 1; dma_we = 0; dma_addr = 32'h40;
    #1 check("t2_ready_lose", dma_ready, 1'b0);
    step();
    core_req = 0; core_we = 0;
    #1 check("t2_ready_win", dma_ready, 1'b1);
    step();
    dma_valid = 0;
    #1 check("t2_rvalid", dma_rvalid, 1'b1);
    check("t2_rdata", dma_rdata, 32'hDEADBEEF);
    step();

    // 3: four back-to-back DMA reads, data returned in order.
    for (int i = 0; i < 4; i++) rec[i] = exp_mem[i];
    for (int i = 0; i < 4; i++) begin
      dma_valid = 1; dma_we = 0; dma_addr = 32'(i);
      #1 check("t3_ready", dma_ready, 1'b1);
      if (i > 0) check("t3_rdata", dma_rdata, rec[i-1]);
      step();
    end
    dma_valid = 0;
    #1 check("t3_rdata_last", dma_rdata, rec[3]);
    step();

    // 4: core hammers the RAM while the DMA waits.
    core_load(32'h50);
    dma_valid = 1; dma_we = 0; dma_addr = 32'h60;
    first_ready = 0;
    for (int c = 1; c <= 12; c++) begin
      #1 if (dma_ready && first_ready == 0) first_ready = c;
      step();
    end
    check("t4_first_ready", first_ready, GUARD ? 9 : 0);
    idle();
    step();
    step();

    // 5: reset lands the cycle after a granted read; the return must vanish.
    core_load(32'h10);
    step();
    reset = 1;
    #1 check("t5_core_rvalid", core_rvalid, 1'b0);
    check("t5_dma_rvalid", dma_rvalid, 1'b0);
    check("t5_stall", core_stall, 1'b0);
    check("t5_en", ram_en, 1'b0);
    step();
    reset = 0;
    idle();
    step();
    core_load(32'h10);
    step();
    idle();
    #1 check("t5_rdata_after", core_rdata, 32'hCAFE0001);
    step();

    // 6: ten idle cycles.
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      #1 pulses += int'(ram_en) + int'(core_rvalid) + int'(dma_rvalid) + int'(core_stall);
      step();
    end
    check("t6_pulses", pulses, 0);

    // Vector table: combinational grant decisions from an idle starting point.
    vt[0] = '{1,0,0,0, 32'h10, 32'h30, 0,0,1,0};
    vt[1] = '{0,0,1,0, 32'h21, 32'h31, 0,1,1,0};
    vt[2] = '{1,1,1,0, 32'h22, 32'h32, 0,0,1,1};
    vt[3] = '{1,0,1,1, 32'h23, 32'h33, 0,0,1,0};
    vt[4] = '{0,0,0,0, 32'h24, 32'h34, 0,0,0,0};
    vt[5] = '{0,0,1,1, 32'h25, 32'h35, 0,1,1,1};
    vt[6] = '{1,1,0,0, 32'h26, 32'h36, 0,0,1,1};
    vt[7] = '{1,0,1,0, 32'h27, 32'h37, 0,0,1,0};
    for (int i = 0; i < 8; i++) begin
      core_req = vt[i].cr; core_we = vt[i].cw; core_addr = vt[i].ca;
      core_wdata = 32'h11110000 + 32'(i);
      dma_valid = vt[i].dv; dma_we = vt[i].dw; dma_addr = vt[i].da;
      dma_wdata = 32'h22220000 + 32'(i);
      #1 check("tbl_stall", core_stall, vt[i].e_stall);
      check("tbl_ready", dma_ready, vt[i].e_ready);
      check("tbl_en", ram_en, vt[i].e_en);
      check("tbl_we", ram_we, vt[i].e_we);
      step();
    end
    idle();
    step();

    // Random traffic: requests are held until granted, occasional async-style reset pulses.
    for (int c = 0; c < 600; c++) begin
      if (!core_req || last_g == 1) begin
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = $urandom_range(0, 1);
        core_addr  = 32'($urandom_range(0, 15));
        core_wdata = $urandom;
      end
      if (!dma_valid || last_g == 2) begin
        dma_valid = $urandom_range(0, 1);
        dma_we    = $urandom_range(0, 1);
        dma_addr  = 32'($urandom_range(0, 15));
        dma_wdata = $urandom;
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
